id_operand_unit: RTL and testbench

- Decode-stage operand unit combining three functions:
  - bypass forwarding of two GPR read values from the MEM and WB write-back buses;
  - 16-bit immediate extension;
  - branch-condition evaluation on the forwarded operands.
- Combinational results feed the decode-stage jump-PC logic.
- A clocked ID/EX operand register captures the forwarded operands and the extended immediate for the execute stage.

---
 rtl/id_operand_unit.sv | 128 ++++++++++++
 tb/tb_id_operand_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: bypass forwarding of the two GPR read values,
// 16-bit immediate extension, branch-condition evaluation, and the ID/EX
// operand register that hands the operands to the execute stage.
module id_operand_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [37:0] mem_back,
    input  logic [37:0] wb_back,
    input  logic        use_mem_back,
    input  logic        use_wb_back,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [15:0] imm,
    input  logic        extop,
    input  logic        exsign,
    input  logic [2:0]  branch_type,
    output logic [31:0] f_rd1,
    output logic [31:0] f_rd2,
    output logic [31:0] ext_b,
    output logic        branch_avail,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_ext
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned IW = 16;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;

    // Unpacked write-back bus fields
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [RW-1:0] mem_rw;
    logic          wb_we;
    logic [DW-1:0] wb_wd;
    logic [RW-1:0] wb_rw;

    assign mem_we = mem_back[37];
    assign mem_wd = mem_back[36:5];
    assign mem_rw = mem_back[4:0];
    assign wb_we  = wb_back[37];
    assign wb_wd  = wb_back[36:5];
    assign wb_rw  = wb_back[4:0];

    // A bus can forward only when enabled, writing, and not targeting r0
    logic mem_live;
    logic wb_live;

    assign mem_live = use_mem_back && mem_we && (mem_rw != RW'(0));
    assign wb_live  = use_wb_back  && wb_we  && (wb_rw  != RW'(0));

    // Forwarding mux for rs; MEM is the younger result and wins over WB
    always_comb begin
        f_rd1 = rd1;
        if (mem_live && (mem_rw == rs)) begin
            f_rd1 = mem_wd;
        end else if (wb_live && (wb_rw == rs)) begin
            f_rd1 = wb_wd;
        end
    end

    // Forwarding mux for rt; same priority as rs
    always_comb begin
        f_rd2 = rd2;
        if (mem_live && (mem_rw == rt)) begin
            f_rd2 = mem_wd;
        end else if (wb_live && (wb_rw == rt)) begin
            f_rd2 = wb_wd;
        end
    end

    // Immediate extension: load-upper, sign-extend or zero-extend
    always_comb begin
        ext_b = {{(DW-IW){1'b0}}, imm};
        if (extop) begin
            ext_b = {imm, {(DW-IW){1'b0}}};
        end else if (exsign) begin
            ext_b = {{(DW-IW){imm[IW-1]}}, imm};
        end
    end

    // Branch condition on forwarded operands, signed compares against zero
    logic signed [DW-1:0] s_rd1;
    assign s_rd1 = $signed(f_rd1);

    always_comb begin
        branch_avail = 1'b0;
        case (branch_type)
            BR_NONE: branch_avail = 1'b0;
            BR_BEQ:  branch_avail = (f_rd1 == f_rd2);
            BR_BNE:  branch_avail = (f_rd1 != f_rd2);
            BR_BLEZ: branch_avail = (s_rd1 <= $signed(DW'(0)));
            BR_BGTZ: branch_avail = (s_rd1 >  $signed(DW'(0)));
            BR_BLTZ: branch_avail = (s_rd1 <  $signed(DW'(0)));
            BR_BGEZ: branch_avail = (s_rd1 >= $signed(DW'(0)));
            default: branch_avail = 1'b0;
        endcase
    end

    // ID/EX operand register: reset dominates, flush clears, otherwise load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd1 <= '0;
            ex_rd2 <= '0;
            ex_ext <= '0;
        end else if (flush) begin
            ex_rd1 <= '0;
            ex_rd2 <= '0;
            ex_ext <= '0;
        end else begin
            ex_rd1 <= f_rd1;
            ex_rd2 <= f_rd2;
            ex_ext <= ext_b;
        end
    end

endmodule

// File: tb/tb_id_operand_unit.sv
// Self-checking bench for id_operand_unit: directed steps followed by
// randomized operands checked against a behavioural reference model.
module tb_id_operand_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [37:0] mem_back;
    logic [37:0] wb_back;
    logic        use_mem_back;
    logic        use_wb_back;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic        extop;
    logic        exsign;
    logic [2:0]  branch_type;
    logic [31:0] f_rd1;
    logic [31:0] f_rd2;
    logic [31:0] ext_b;
    logic        branch_avail;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_ext;

    int total = 0;
    int bad   = 0;

    id_operand_unit dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .mem_back     (mem_back),
        .wb_back      (wb_back),
        .use_mem_back (use_mem_back),
        .use_wb_back  (use_wb_back),
        .rs           (rs),
        .rt           (rt),
        .rd1          (rd1),
        .rd2          (rd2),
        .imm          (imm),
        .extop        (extop),
        .exsign       (exsign),
        .branch_type  (branch_type),
        .f_rd1        (f_rd1),
        .f_rd2        (f_rd2),
        .ext_b        (ext_b),
        .branch_avail (branch_avail),
        .ex_rd1       (ex_rd1),
        .ex_rd2       (ex_rd2),
        .ex_ext       (ex_ext)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: which value does a consumer of register idx actually see?
    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] gpr);
        logic [31:0] mem_data;
        logic [31:0] wb_data;
        int          mem_dst;
        int          wb_dst;
        mem_data = mem_back[36:5];
        wb_data  = wb_back[36:5];
        mem_dst  = int'(mem_back[4:0]);
        wb_dst   = int'(wb_back[4:0]);
        if (idx == 5'd0) return gpr;
        if (use_mem_back && mem_back[37] && mem_dst == int'(idx)) return mem_data;
        if (use_wb_back && wb_back[37] && wb_dst == int'(idx)) return wb_data;
        return gpr;
    endfunction

    function automatic logic [31:0] m_ext();
        int v;
        v = int'(imm);
        if (extop) return 32'(v * 65536);
        if (exsign && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    function automatic logic m_br(input logic [31:0] a_u, input logic [31:0] b_u);
        int a;
        int b;
        a = int'(signed'(a_u));
        b = int'(signed'(b_u));
        case (int'(branch_type))
            1: return a == b;
            2: return a != b;
            3: return a <= 0;
            4: return a > 0;
            5: return a < 0;
            6: return a >= 0;
            default: return 1'b0;
        endcase
    endfunction

    logic [31:0] e1, e2, ee, keep;

    initial begin
        rst = 1'b1; flush = 1'b0;
        mem_back = '0; wb_back = '0; use_mem_back = 1'b0; use_wb_back = 1'b0;
        rs = '0; rt = '0; rd1 = '0; rd2 = '0; imm = '0;
        extop = 1'b0; exsign = 1'b0; branch_type = '0;

        #2;
        chk("reset_ex_rd1", ex_rd1, 32'h0);
        chk("reset_ex_rd2", ex_rd2, 32'h0);
        chk("reset_ex_ext", ex_ext, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Forward priority
        rs = 5'd5; rd1 = 32'h11111111;
        mem_back = {1'b1, 32'hAAAAAAAA, 5'd5};
        wb_back  = {1'b1, 32'hBBBBBBBB, 5'd5};
        use_mem_back = 1'b1; use_wb_back = 1'b1;
        #1 chk("prio_mem", f_rd1, 32'hAAAAAAAA);
        use_mem_back = 1'b0;
        #1 chk("prio_wb", f_rd1, 32'hBBBBBBBB);
        wb_back = {1'b0, 32'hBBBBBBBB, 5'd5};
        #1 chk("prio_gpr", f_rd1, 32'h11111111);

        // Register 0 guard
        use_mem_back = 1'b1;
        rs = 5'd0; rd1 = 32'h0;
        mem_back = {1'b1, 32'hDEADBEEF, 5'd0};
        #1 chk("r0_guard", f_rd1, 32'h0);

        // Extension
        imm = 16'h8001; extop = 1'b0; exsign = 1'b1;
        #1 chk("ext_sign", ext_b, 32'hFFFF8001);
        exsign = 1'b0;
        #1 chk("ext_zero", ext_b, 32'h00008001);
        extop = 1'b1;
        #1 chk("ext_lui", ext_b, 32'h80010000);

        // Branch
        mem_back = '0; wb_back = '0;
        rs = 5'd1; rt = 5'd2; rd1 = 32'd7; rd2 = 32'd7;
        branch_type = 3'd1;
        #1 chk("beq_eq", 32'(branch_avail), 32'd1);
        branch_type = 3'd2;
        #1 chk("bne_eq", 32'(branch_avail), 32'd0);
        rd1 = 32'h80000000;
        branch_type = 3'd3; #1 chk("blez_neg", 32'(branch_avail), 32'd1);
        branch_type = 3'd4; #1 chk("bgtz_neg", 32'(branch_avail), 32'd0);
        branch_type = 3'd5; #1 chk("bltz_neg", 32'(branch_avail), 32'd1);
        branch_type = 3'd6; #1 chk("bgez_neg", 32'(branch_avail), 32'd0);
        rd1 = 32'h0;
        branch_type = 3'd3; #1 chk("blez_zero", 32'(branch_avail), 32'd1);
        branch_type = 3'd6; #1 chk("bgez_zero", 32'(branch_avail), 32'd1);
        branch_type = 3'd4; #1 chk("bgtz_zero", 32'(branch_avail), 32'd0);
        rd2 = 32'h0;
        branch_type = 3'd7; #1 chk("reserved", 32'(branch_avail), 32'd0);
        rs = 5'd3; mem_back = {1'b1, 32'd5, 5'd3};
        branch_type = 3'd4; #1 chk("bgtz_fwd", 32'(branch_avail), 32'd1);

        // Register stage
        @(negedge clk);
        mem_back = '0; rs = 5'd1; rd1 = 32'h12345678; rd2 = 32'hCAFEF00D;
        imm = 16'h1234; extop = 1'b0; exsign = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("reg_load_rd1", ex_rd1, 32'h12345678);
        chk("reg_load_rd2", ex_rd2, 32'hCAFEF00D);
        chk("reg_load_ext", ex_ext, 32'h00001234);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_rd1", ex_rd1, 32'h0);
        chk("flush_rd2", ex_rd2, 32'h0);
        chk("flush_ext", ex_ext, 32'h0);
        flush = 1'b0;

        // Async reset
        @(posedge clk); #1;
        chk("pre_rst_load", ex_rd1, 32'h12345678);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rd1", ex_rd1, 32'h0);
        chk("async_rd2", ex_rd2, 32'h0);
        chk("async_ext", ex_ext, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_rd1", ex_rd1, 32'h0);
            chk("rst_hold_ext", ex_ext, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_release_quiet", ex_rd1, 32'h0);
        @(posedge clk); #1;
        chk("rst_release_load", ex_rd1, 32'h12345678);
        chk("rst_release_ext", ex_ext, 32'h00001234);

        // Randomized operands against the reference model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            use_mem_back = 1'($urandom);
            use_wb_back  = 1'($urandom);
            mem_back = {1'($urandom), 32'($urandom), 5'($urandom_range(0, 3))};
            wb_back  = {1'($urandom), 32'($urandom), 5'($urandom_range(0, 3))};
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            keep = 32'($urandom);
            case ($urandom_range(0, 3))
                0: rd1 = 32'h0;
                1: rd1 = 32'h80000000 | keep;
                default: rd1 = keep;
            endcase
            rd2 = ($urandom_range(0, 2) == 0) ? rd1 : 32'($urandom);
            imm    = 16'($urandom);
            extop  = 1'($urandom);
            exsign = 1'($urandom);
            branch_type = 3'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            #1;
            e1 = m_fwd(rs, rd1);
            e2 = m_fwd(rt, rd2);
            ee = m_ext();
            chk("rnd_f_rd1", f_rd1, e1);
            chk("rnd_f_rd2", f_rd2, e2);
            chk("rnd_ext_b", ext_b, ee);
            chk("rnd_branch", 32'(branch_avail), 32'(m_br(e1, e2)));
            @(posedge clk); #1;
            chk("rnd_ex_rd1", ex_rd1, flush ? 32'h0 : e1);
            chk("rnd_ex_rd2", ex_rd2, flush ? 32'h0 : e2);
            chk("rnd_ex_ext", ex_ext, flush ? 32'h0 : ee);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
